// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the weight loader; macro WEIGHT_LOADER_CHECKSUM_EN adds checksum checking.
// Element width comes from `WEIGHT_LOADER_DATA_LEN when provided; it falls back to 8 bits when that is absent.
// FSM state encodings are fixed so they match the read-side tooling.
`ifndef WEIGHT_LOADER_DATA_LEN
`define WEIGHT_LOADER_DATA_LEN 8
`endif

package weight_loader_pkg;

    localparam int DATA_LEN = `WEIGHT_LOADER_DATA_LEN;
    localparam int ELEMS    = 9;
    localparam int CNT_W    = $clog2(ELEMS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/weight_loader_if.sv
// Element stream in and memory write port out, grouped so that one bundle carries both.
// The slave side is the loader; the master side is the host/DMA plus the memory model.
// s_ready is the only signal that flows back to the stream source.
interface weight_loader_if #(
    parameter int AWIDTH = 8
);
    import weight_loader_pkg::*;

    localparam int DWIDTH = ELEMS * DATA_LEN;

    logic [DATA_LEN-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic                we;
    logic [AWIDTH-1:0]   waddr;
    logic [DWIDTH-1:0]   wdata;

    modport slave  (input  s_data, s_valid, output s_ready, we, waddr, wdata);
    modport master (output s_data, s_valid, input  s_ready, we, waddr, wdata);

endinterface

// File: rtl/weight_loader_elem_packer.sv
// Packs ELEMS consecutive elements into one word, with the first element in the LSBs.
// Latency: the word is presented one cycle after the handshake of its last element.
// Backpressure: none; every accepted element is absorbed, and each word is a one-cycle pulse.
module weight_loader_elem_packer
    import weight_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clr,
    input  logic                      i_vld,
    input  logic [DATA_LEN-1:0]       i_dat,
    output logic                      o_last,
    output logic                      o_word_vld,
    output logic [ELEMS*DATA_LEN-1:0] o_word
);

    logic [CNT_W-1:0]          r_cnt;
    logic [ELEMS*DATA_LEN-1:0] r_shift;
    logic [ELEMS*DATA_LEN-1:0] r_word;
    logic                      r_word_vld;
    logic [ELEMS*DATA_LEN-1:0] w_ins;

    assign o_last     = (r_cnt == CNT_W'(ELEMS - 1));
    assign o_word_vld = r_word_vld;
    assign o_word     = r_word;

    // Place the incoming element into its slot of the partially built word.
    always_comb begin
        w_ins = r_shift;
        w_ins[int'(r_cnt) * DATA_LEN +: DATA_LEN] = i_dat;
    end

    // Element counter and packing register; latch the full word on the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_word     <= '0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= 1'b0;
            if (i_clr) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (i_vld) begin
                r_shift <= w_ins;
                if (o_last) begin
                    r_cnt      <= '0;
                    r_word     <= w_ins;
                    r_word_vld <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Streams weight elements into the weight RAM, one packed word per write, to addresses 0..WORDS-1; WEIGHT_LOADER_CHECKSUM_EN adds a trailing checksum.
// Latency: each write appears one cycle after the last element of its word, and done follows the final element (or the checksum).
// Backpressure: s_ready is high throughout LOAD/CHECK, so the source alone paces the load.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int WORDS  = 5 * 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    weight_loader_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DWIDTH = ELEMS * DATA_LEN;

    state_t              r_state;
    state_t              w_next;
    logic [AWIDTH-1:0]   r_wcnt;
    logic [AWIDTH-1:0]   r_waddr;
    logic                w_s_ready;
    logic                w_hs;
    logic                w_elem_hs;
    logic                w_start_acc;
    logic                w_pk_last;
    logic                w_last_elem;
    logic                w_word_vld;
    logic [DWIDTH-1:0]   w_word;

    assign w_hs        = bus.s_valid & w_s_ready;
    assign w_elem_hs   = w_hs & (r_state == ST_LOAD);
    assign w_start_acc = start & (r_state == ST_IDLE);
    assign w_last_elem = w_elem_hs & w_pk_last & (r_wcnt == AWIDTH'(WORDS - 1));

    weight_loader_elem_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_start_acc),
        .i_vld      (w_elem_hs),
        .i_dat      (bus.s_data),
        .o_last     (w_pk_last),
        .o_word_vld (w_word_vld),
        .o_word     (w_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: start opens a load, the final element (or checksum) closes it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_acc) w_next = ST_LOAD;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            ST_LOAD:  if (w_last_elem) w_next = ST_CHECK;
            ST_CHECK: if (w_hs)        w_next = ST_FIN;
`else
            ST_LOAD:  if (w_last_elem) w_next = ST_FIN;
`endif
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        w_s_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_LOAD:  begin w_s_ready = 1'b1; busy = 1'b1; end
            ST_CHECK: begin w_s_ready = 1'b1; busy = 1'b1; end
            ST_FIN:   begin busy = 1'b1; done = 1'b1; end
            default:  ;
        endcase
    end

    // Word counter feeds the write address; it stops at the last word and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt  <= '0;
            r_waddr <= '0;
        end else if (w_start_acc) begin
            r_wcnt <= '0;
        end else if (w_elem_hs && w_pk_last) begin
            r_waddr <= r_wcnt;
            if (r_wcnt != AWIDTH'(WORDS - 1)) r_wcnt <= r_wcnt + 1'b1;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.we      = w_word_vld;
    assign bus.waddr   = r_waddr;
    assign bus.wdata   = w_word;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [DATA_LEN-1:0] r_sum;
    logic                r_err;

    // Running sum of weight elements, compared against the trailing checksum element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_elem_hs) r_sum <= r_sum + bus.s_data;
            if (w_hs && r_state == ST_CHECK) r_err <= (bus.s_data != r_sum);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: a 3-word instance for function, stalls, start and reset, plus a default 160-word instance.
// Expected writes are queued as elements are driven and then checked against each we pulse.
// All sampling happens on the falling clock edge.
module tb_weight_loader;
    import weight_loader_pkg::*;

    localparam int DL = DATA_LEN;
    localparam int DW = ELEMS * DATA_LEN;
    localparam int AW = 8;
    localparam int WA = 3;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          drv_start = 1'b0;
    logic          drv_vld   = 1'b0;
    logic          sel       = 1'b0;
    logic [DL-1:0] drv_dat   = '0;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;

    weight_loader_if #(.AWIDTH(AW)) a_if ();
    weight_loader_if #(.AWIDTH(AW)) b_if ();

    assign a_if.s_data  = drv_dat;
    assign a_if.s_valid = drv_vld & ~sel;
    assign b_if.s_data  = drv_dat;
    assign b_if.s_valid = drv_vld & sel;

    weight_loader #(.AWIDTH(AW), .WORDS(WA)) u_a (
        .clk(clk), .rst_n(rst_n), .start(drv_start & ~sel), .bus(a_if.slave),
        .busy(busy_a), .done(done_a), .err(err_a)
    );
    weight_loader #(.AWIDTH(AW)) u_b (
        .clk(clk), .rst_n(rst_n), .start(drv_start & sel), .bus(b_if.slave),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    logic          m_rdy, m_we, m_busy, m_done, m_err;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    assign m_rdy   = sel ? b_if.s_ready : a_if.s_ready;
    assign m_we    = sel ? b_if.we      : a_if.we;
    assign m_waddr = sel ? b_if.waddr   : a_if.waddr;
    assign m_wdata = sel ? b_if.wdata   : a_if.wdata;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_err   = sel ? err_b  : err_a;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           q[$];
    int            total = 0;
    int            bad = 0;
    int            wr_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ref_mem [0:WA-1];

    // Write monitor: every we pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && m_we === 1'b1) begin
            wr_cnt++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: waddr=%0d wdata=%h, required no write", m_waddr, m_wdata);
            end else begin
                e = q.pop_front();
                if (m_waddr !== e.a || m_wdata !== e.d) begin
                    bad++;
                    $display("FAIL write_data: waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                             m_waddr, m_wdata, e.a, e.d);
                end
            end
            mem[m_waddr] = m_wdata;
            last_addr = m_waddr;
        end
    end

    task automatic put(input logic [DL-1:0] d);
        int t;
        t = 0;
        drv_dat = d;
        drv_vld = 1'b1;
        while (m_rdy !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (m_rdy !== 1'b1) begin
            bad++;
            $display("FAIL put_timeout: s_ready=%b, required 1", m_rdy);
            drv_vld = 1'b0;
        end else begin
            @(negedge clk);
            drv_vld = 1'b0;
        end
    endtask

    task automatic do_load(input int nw, input int base, input int gap, input bit bad_ck, input bit mid_start);
        logic [DW-1:0] word;
        logic [DL-1:0] v;
        logic [DL-1:0] sum;
        wr_t           e;
        sum = '0;
        drv_start = 1'b1;
        @(negedge clk);
        drv_start = 1'b0;
        total++;
        if (m_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start: busy=%b, required 1", m_busy);
        end
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < ELEMS; k++) begin
                v = DL'(base + w * ELEMS + k);
                word[k*DL +: DL] = v;
                sum = sum + v;
                while (gap > 0 && $urandom_range(99) < gap) @(negedge clk);
                if (k == ELEMS - 1) begin
                    e.a = AW'(w);
                    e.d = word;
                    q.push_back(e);
                end
                if (mid_start && w == 0 && k == 3) drv_start = 1'b1;
                put(v);
                drv_start = 1'b0;
                if (k == ELEMS - 1) begin
                    total++;
                    if (m_we !== 1'b1 || m_waddr !== AW'(w)) begin
                        bad++;
                        $display("FAIL write_latency: we=%b waddr=%0d, required we=1 waddr=%0d", m_we, m_waddr, w);
                    end
                end
            end
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        total++;
        if (m_done !== 1'b0 || m_rdy !== 1'b1) begin
            bad++;
            $display("FAIL check_wait: done=%b s_ready=%b, required done=0 s_ready=1", m_done, m_rdy);
        end
        put(bad_ck ? sum + 1'b1 : sum);
        total++;
        if (m_done !== 1'b1 || m_err !== bad_ck) begin
            bad++;
            $display("FAIL done_cksum: done=%b err=%b, required done=1 err=%b", m_done, m_err, bad_ck);
        end
`else
        total++;
        if (m_done !== 1'b1 || m_rdy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b s_ready=%b, required done=1 s_ready=0", m_done, m_rdy);
        end
`endif
        @(negedge clk);
        total++;
        if (m_done !== 1'b0 || m_busy !== 1'b0 || m_we !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_done: done=%b busy=%b we=%b, required 0 0 0", m_done, m_busy, m_we);
        end
        total++;
        if (m_err !== (CK & bad_ck)) begin
            bad++;
            $display("FAIL err_hold: err=%b, required %b", m_err, CK & bad_ck);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if (a_if.we !== 1'b0 || a_if.waddr !== '0 || a_if.wdata !== '0) begin
            bad++;
            $display("FAIL reset_write: we=%b waddr=%0d wdata=%h, required all 0", a_if.we, a_if.waddr, a_if.wdata);
        end
        total++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0 || a_if.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: busy=%b done=%b err=%b s_ready=%b, required all 0",
                     busy_a, done_a, err_a, a_if.s_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int w0;
        w0 = wr_cnt;
        do_load(WA, 1, 0, 1'b0, 1'b0);
        total++;
        if (wr_cnt - w0 != WA) begin
            bad++;
            $display("FAIL basic_count: writes=%0d, required %0d", wr_cnt - w0, WA);
        end
        total++;
        if (mem[0][7:0] !== 8'd1 || mem[0][71:64] !== 8'd9 || mem[1][7:0] !== 8'd10 || mem[2][71:64] !== 8'd27) begin
            bad++;
            $display("FAIL basic_fields: w0=%h w1=%h w2=%h, required field0 1/10 and field8 9/27", mem[0], mem[1], mem[2]);
        end
        total++;
        if (m_waddr !== AW'(2) || m_wdata !== mem[2]) begin
            bad++;
            $display("FAIL hold_last: waddr=%0d wdata=%h, required waddr=2 wdata=%h", m_waddr, m_wdata, mem[2]);
        end
        for (int i = 0; i < WA; i++) ref_mem[i] = mem[i];
    endtask

    task automatic test_stalls;
        int w0;
        w0 = wr_cnt;
        for (int i = 0; i < WA; i++) mem[i] = '0;
        do_load(WA, 1, 50, 1'b0, 1'b0);
        total++;
        if (wr_cnt - w0 != WA) begin
            bad++;
            $display("FAIL stall_count: writes=%0d, required %0d", wr_cnt - w0, WA);
        end
        for (int i = 0; i < WA; i++) begin
            total++;
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                $display("FAIL stall_mem: addr=%0d got=%h, required %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        int w0;
        w0 = wr_cnt;
        do_load(WA, 40, 0, 1'b0, 1'b1);
        total++;
        if (wr_cnt - w0 != WA || last_addr !== AW'(WA - 1)) begin
            bad++;
            $display("FAIL start_ignored: writes=%0d last=%0d, required %0d last=%0d", wr_cnt - w0, last_addr, WA, WA - 1);
        end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] word;
        wr_t           e;
        drv_start = 1'b1;
        @(negedge clk);
        drv_start = 1'b0;
        for (int i = 0; i < ELEMS + 5; i++) begin
            if (i < ELEMS) word[i*DL +: DL] = DL'(100 + i);
            if (i == ELEMS - 1) begin
                e.a = '0;
                e.d = word;
                q.push_back(e);
            end
            put(DL'(100 + i));
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (a_if.we !== 1'b0 || a_if.waddr !== '0 || a_if.wdata !== '0 || busy_a !== 1'b0 ||
            done_a !== 1'b0 || err_a !== 1'b0 || a_if.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: we=%b waddr=%0d wdata=%h busy=%b done=%b err=%b s_ready=%b, required all 0",
                     a_if.we, a_if.waddr, a_if.wdata, busy_a, done_a, err_a, a_if.s_ready);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_load(WA, 200, 0, 1'b0, 1'b0);
        total++;
        if (mem[0][7:0] !== 8'd200 || mem[0][15:8] !== 8'd201) begin
            bad++;
            $display("FAIL reload_lsb: word0=%h, required fields 0/1 = c8/c9", mem[0]);
        end
    endtask

    task automatic test_checksum;
        do_load(WA, 1, 0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if (m_err !== CK) begin
            bad++;
            $display("FAIL err_persist: err=%b, required %b", m_err, CK);
        end
        do_load(WA, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_full;
        int w0;
        sel = 1'b1;
        @(negedge clk);
        w0 = wr_cnt;
        do_load(160, 7, 0, 1'b0, 1'b0);
        total++;
        if (wr_cnt - w0 != 160 || last_addr !== AW'(159)) begin
            bad++;
            $display("FAIL full_load: writes=%0d last=%0d, required 160 last=159", wr_cnt - w0, last_addr);
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: pending=%0d, required 0", q.size());
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_start_ignored();
        test_reset_mid();
        test_checksum();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Write-side counterpart of the weight ROM.
- Accepts a stream of single `data_len`-bit weight elements over a valid/ready handshake and packs 9 consecutive elements into one 9*`data_len` word.
- Writes the packed words sequentially into the weight memory's write port: one write per word, addresses 0..WORDS-1.
- Sits between the host/DMA stream and the weight block RAM, so weights are loaded at run time instead of from an init file.

Parameters:
- ELEMS, 9, elements packed per memory word.
- DWIDTH, ELEMS*`data_len, memory word width.
- AWIDTH, 8, memory address width.
- WORDS, 5*32, number of words per load (must be ≤ 2^AWIDTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a load when idle.
- s_data  in  `data_len  weight element.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- we  out  1  memory write enable, single-cycle per word.
- waddr  out  AWIDTH  memory write address.
- wdata  out  DWIDTH  packed memory word.
- busy  out  1  high from accepted start until done.
- done  out  1  single-cycle pulse when the load completes.
- err  out  1  checksum mismatch flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0) values:
  - All outputs 0, including we, waddr, wdata, done, err.
  - FSM in IDLE; element counter and word counter cleared.
  - Reset mid-load abandons the load; words already written are not rolled back.
- FSM states: IDLE, LOAD, CHECK (only with feature), FIN.
- IDLE:
  - s_ready=0, busy=0.
  - start=1 moves to LOAD: clears element counter, word counter and packing register; clears err.
- LOAD:
  - busy=1, s_ready=1; no backpressure is needed because a write never stalls.
  - A handshake occurs when s_valid & s_ready.
  - Element k (0..ELEMS-1) of a word occupies bits [k*`data_len +: `data_len]; the first element goes to the LSBs.
  - On the handshake of element ELEMS-1, the next cycle shows we=1, waddr=word counter and wdata=the complete word. Write latency is 1 cycle after the last element.
  - The element counter wraps 8→0 and the word counter increments at that handshake.
  - Back-to-back words are legal; we may be high on consecutive words' boundaries.
  - After the final element of word WORDS-1 is accepted, s_ready drops in the same registered update. Next state is FIN, or CHECK with the feature enabled.
- FIN:
  - The final write (we=1) occurs in this cycle.
  - done=1 for exactly this cycle, busy=0 from the following cycle, then return to IDLE.
- start is ignored while busy.
- s_valid low in LOAD simply stalls; no timeout.
- we is low outside the single write cycles. waddr and wdata hold their last values when we=0.
- Counters are sized $clog2(ELEMS) and AWIDTH; there is no wrap beyond WORDS-1.

Optional Feature:
- Macro: WEIGHT_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a running sum of all accepted elements, modulo 2^`data_len.
  - After the last element, it enters CHECK with s_ready=1 and accepts exactly one additional element as the checksum.
  - err is set when the checksum ≠ running sum. err holds until the next accepted start or reset.
  - The final memory write occurs normally in the cycle after the last weight element; it does not wait for the checksum.
  - FIN (done pulse) follows the checksum handshake.
- Undefined:
  - No CHECK state.
  - err is tied to 0.
  - The stream carries exactly WORDS*ELEMS elements.

Decomposition:
- Shared package/include:
  - `data_len (existing num_data.v).
  - ELEMS.
  - FSM state encodings (IDLE=0, LOAD=1, CHECK=2, FIN=3).
- One natural sub-module, elem_packer: shift/insert register plus element counter. It produces word_valid and word, and is instantiated once. The FSM, address counter and checksum stay in weight_loader.

Test Plan:
- Basic load with WORDS=2, elements 1..18 streamed continuously → we at waddr 0 with wdata fields {9,8,...,1} (field 0=1), then waddr 1 with fields 10..18 (field 0=10); done pulses once; busy falls.
- Stalls: random s_valid gaps (≈50%), WORDS=3 → identical memory contents to the gap-free run; exactly 3 we pulses; no write while an element is missing.
- start pulsed during LOAD → ignored; counters unaffected; addresses still 0..WORDS-1.
- rst_n asserted mid-word (after element 4 of word 1) → all outputs 0 immediately; a fresh start then writes from waddr 0 with element 0 in the LSBs.
- Default WORDS=160 full load → 160 writes, last at waddr 159; s_ready low after the 1440th element.
- With WEIGHT_LOADER_CHECKSUM_EN, WORDS=1, elements 1..9:
  - checksum 45 → err=0, done pulses.
  - checksum 44 → err=1 after done.
